// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port synchronous data memory between
// the CPU load/store port (fixed priority) and the debug/DMA port. A debug
// request that has been stalled MAX_DEFER consecutive cycles is given a
// forced slot in which the CPU is held off for exactly one cycle.
// Read data returns one cycle after accept and is steered back to the
// requester that issued the read.
// Optional build macro DMEM_ARB_STATS_EN adds the conflict_cnt and force_cnt
// statistics outputs; arbitration is identical with or without it.

module dmem_port_arbiter #(
  parameter int AW        = 14,
  parameter int DW        = 32,
  parameter int MAX_DEFER = 8
) (
  input  logic            CLK,
  input  logic            RST_N,

  input  logic            cpu_req_valid,
  output logic            cpu_req_ready,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  input  logic [DW/8-1:0] cpu_be,
  output logic            cpu_rvalid,
  output logic [DW-1:0]   cpu_rdata,

  input  logic            dbg_req_valid,
  output logic            dbg_req_ready,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [DW-1:0]   dbg_wdata,
  input  logic [DW/8-1:0] dbg_be,
  output logic            dbg_rvalid,
  output logic [DW-1:0]   dbg_rdata,

  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]     conflict_cnt,
  output logic [15:0]     force_cnt
`endif
);

  localparam logic [7:0] DEFER_MAX = 8'(MAX_DEFER);

  localparam logic [0:0] ST_ARB       = 1'b0;
  localparam logic [0:0] ST_FORCE_DBG = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [7:0]    defer_cnt;
  logic [7:0]    defer_nxt;

  logic          cpu_fire;
  logic          dbg_fire;

  logic          rd_cpu_q;
  logic          rd_dbg_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dbg_rdata_q;

  // Grant decision: CPU first in ARB, debug only in its forced slot otherwise;
  // nothing is granted while reset is asserted.
  always_comb begin
    cpu_req_ready = 1'b0;
    dbg_req_ready = 1'b0;
    if (RST_N) begin
      if (state == ST_FORCE_DBG) begin
        dbg_req_ready = dbg_req_valid;
      end else begin
        cpu_req_ready = cpu_req_valid;
        dbg_req_ready = dbg_req_valid && !cpu_req_valid;
      end
    end
  end

  assign cpu_fire = cpu_req_valid && cpu_req_ready;
  assign dbg_fire = dbg_req_valid && dbg_req_ready;

  // Memory port mux: drive the winner's request, all zeros when idle.
  always_comb begin
    mem_en    = cpu_fire || dbg_fire;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (cpu_fire) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_be    = cpu_be;
    end else if (dbg_fire) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_be    = dbg_be;
    end
  end

  // Starvation guard: count consecutive debug stalls, force a debug slot at the limit.
  always_comb begin
    state_nxt = state;
    defer_nxt = defer_cnt;
    case (state)
      ST_ARB: begin
        if (dbg_req_valid && !dbg_req_ready) begin
          defer_nxt = (defer_cnt >= DEFER_MAX) ? DEFER_MAX : defer_cnt + 8'd1;
        end else begin
          defer_nxt = '0;
        end
        if (defer_nxt == DEFER_MAX) begin
          state_nxt = ST_FORCE_DBG;
        end
      end
      ST_FORCE_DBG: begin
        defer_nxt = '0;
        state_nxt = ST_ARB;
      end
      default: begin
        defer_nxt = '0;
        state_nxt = ST_ARB;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_ARB;
      defer_cnt <= '0;
    end else begin
      state     <= state_nxt;
      defer_cnt <= defer_nxt;
    end
  end

  // Read-owner tracking and per-port hold of the last returned read data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_cpu_q    <= 1'b0;
      rd_dbg_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      rd_cpu_q <= cpu_fire && !cpu_we;
      rd_dbg_q <= dbg_fire && !dbg_we;
      if (rd_cpu_q) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (rd_dbg_q) begin
        dbg_rdata_q <= mem_rdata;
      end
    end
  end

  // Memory read data is only valid in the response cycle, so the owning port
  // sees it directly then and its held copy afterwards.
  assign cpu_rvalid = rd_cpu_q;
  assign dbg_rvalid = rd_dbg_q;
  assign cpu_rdata  = rd_cpu_q ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata  = rd_dbg_q ? mem_rdata : dbg_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic force_entry;

  assign force_entry = (state == ST_ARB) && (state_nxt == ST_FORCE_DBG);

  // Statistics: saturating conflict-cycle count and wrapping forced-slot count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      conflict_cnt <= '0;
      force_cnt    <= '0;
    end else begin
      if (cpu_req_valid && dbg_req_valid && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
      if (force_entry) begin
        force_cnt <= force_cnt + 16'd1;
      end
    end
  end
`else
  // Statistics outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model (stall-run counter, pending-read records, word memory).

module tb_dmem_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MAXD = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;

  logic          cpu_req_valid = 1'b0;
  logic          cpu_req_ready;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [BW-1:0] cpu_be = '0;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          dbg_req_valid = 1'b0;
  logic          dbg_req_ready;
  logic          dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic [BW-1:0] dbg_be = '0;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata = '0;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   conflict_cnt;
  logic [15:0]   force_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DEFER(MAXD)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_be        (cpu_be),
    .cpu_rvalid    (cpu_rvalid),
    .cpu_rdata     (cpu_rdata),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_ready (dbg_req_ready),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_be        (dbg_be),
    .dbg_rvalid    (dbg_rvalid),
    .dbg_rdata     (dbg_rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rdata     (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .conflict_cnt  (conflict_cnt),
    .force_cnt     (force_cnt)
`endif
  );

  initial forever #5 CLK = ~CLK;

  // Synchronous single-port data memory with byte enables, one-cycle read.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) ram[i] = '0;

  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [DW-1:0] mdl_mem [int];
  int            stall_run = 0;
  bit            pend_c = 0, pend_d = 0;
  logic [DW-1:0] pdata_c = '0, pdata_d = '0;
  logic [DW-1:0] held_c = '0, held_d = '0;
  bit            c_fired = 0, d_fired = 0, d_fired_rd = 0;

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    if (mdl_mem.exists(int'(a))) return mdl_mem[int'(a)];
    return '0;
  endfunction

  task automatic mwrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    logic [DW-1:0] w;
    w = mread(a);
    for (int b = 0; b < BW; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
    mdl_mem[int'(a)] = w;
  endtask

  // Model update at each clock edge (and asynchronous reset).
  initial forever begin
    bit forced, cg, dg;
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      stall_run = 0; pend_c = 0; pend_d = 0; held_c = '0; held_d = '0;
      c_fired = 0; d_fired = 0; d_fired_rd = 0;
    end else begin
      if (pend_c) held_c = pdata_c;
      if (pend_d) held_d = pdata_d;
      forced = (stall_run == MAXD);
      cg = !forced && cpu_req_valid;
      dg = forced ? dbg_req_valid : (dbg_req_valid && !cpu_req_valid);
      pend_c = 0; pend_d = 0;
      if (cg) begin
        if (cpu_we) mwrite(cpu_addr, cpu_wdata, cpu_be);
        else begin pend_c = 1; pdata_c = mread(cpu_addr); end
      end
      if (dg) begin
        if (dbg_we) mwrite(dbg_addr, dbg_wdata, dbg_be);
        else begin pend_d = 1; pdata_d = mread(dbg_addr); end
      end
      if (forced) stall_run = 0;
      else if (dbg_req_valid && !dg) stall_run = stall_run + 1;
      else stall_run = 0;
      c_fired = cg; d_fired = dg; d_fired_rd = dg && !dbg_we;
    end
  end

  // Per-cycle compare of every output against the model, away from the clock edge.
  initial forever begin
    bit forced, e_cr, e_dr;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_be;
    @(negedge CLK);
    forced = RST_N && (stall_run == MAXD);
    e_cr = RST_N && !forced && cpu_req_valid;
    e_dr = RST_N && (forced ? dbg_req_valid : (dbg_req_valid && !cpu_req_valid));
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
    if (e_cr) begin
      e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata; e_be = cpu_be;
    end else if (e_dr) begin
      e_we = dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata; e_be = dbg_be;
    end
    chk("cpu_req_ready", cpu_req_ready, e_cr);
    chk("dbg_req_ready", dbg_req_ready, e_dr);
    chk("mem_en", mem_en, e_cr || e_dr);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_be", mem_be, e_be);
    chk("cpu_rvalid", cpu_rvalid, pend_c);
    chk("dbg_rvalid", dbg_rvalid, pend_d);
    chk("cpu_rdata", cpu_rdata, pend_c ? pdata_c : held_c);
    chk("dbg_rdata", dbg_rdata, pend_d ? pdata_d : held_d);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    dbg_req_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_be = '0;
  endtask

  task automatic cpu_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    cpu_req_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = be;
  endtask

  task automatic dbg_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    dbg_req_valid = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_be = be;
  endtask

  task automatic do_reset(input int cycles);
    RST_N = 1'b0;
    repeat (cycles) tick();
    RST_N = 1'b1;
  endtask

  initial begin
    int phase;
    idle();
    do_reset(3);

    // CPU write then read back of 14'h0010.
    cpu_req(1'b1, 14'h0010, 32'hDEADBEEF, 4'hF);
    #1 chk("t2_wr_ready", cpu_req_ready, 1'b1);
    tick();
    cpu_req(1'b0, 14'h0010, '0, 4'hF);
    #1 chk("t2_rd_ready", cpu_req_ready, 1'b1);
    tick();
    idle();
    #1;
    chk("t2_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("t2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t2_dbg_rvalid", dbg_rvalid, 1'b0);
    tick();

    // Simultaneous requests: CPU wins, debug follows next cycle.
    cpu_req(1'b0, 14'h0001, '0, 4'hF);
    dbg_req(1'b0, 14'h0002, '0, 4'hF);
    #1;
    chk("t3_cpu_ready", cpu_req_ready, 1'b1);
    chk("t3_dbg_ready", dbg_req_ready, 1'b0);
    chk("t3_mem_addr", mem_addr, 14'h0001);
    tick();
    cpu_req_valid = 1'b0;
    #1 chk("t3_dbg_late_ready", dbg_req_ready, 1'b1);
    tick();
    idle();
    tick();

    // Preload two words through the debug port, then alternate reads.
    dbg_req(1'b1, 14'h0003, 32'h1111_1111, 4'hF);
    tick();
    dbg_req(1'b1, 14'h0004, 32'h2222_2222, 4'hF);
    tick();
    idle();
    cpu_req(1'b0, 14'h0003, '0, 4'hF);
    tick();
    idle();
    dbg_req(1'b0, 14'h0004, '0, 4'hF);
    #1;
    chk("t5_a_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("t5_a_cpu_rdata", cpu_rdata, 32'h1111_1111);
    chk("t5_a_dbg_rvalid", dbg_rvalid, 1'b0);
    tick();
    idle();
    cpu_req(1'b0, 14'h0004, '0, 4'hF);
    #1;
    chk("t5_b_dbg_rvalid", dbg_rvalid, 1'b1);
    chk("t5_b_dbg_rdata", dbg_rdata, 32'h2222_2222);
    chk("t5_b_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("t5_b_cpu_hold", cpu_rdata, 32'h1111_1111);
    tick();
    idle();
    dbg_req(1'b0, 14'h0003, '0, 4'hF);
    #1;
    chk("t5_c_cpu_rdata", cpu_rdata, 32'h2222_2222);
    chk("t5_c_dbg_hold", dbg_rdata, 32'h2222_2222);
    chk("t5_c_dbg_rvalid", dbg_rvalid, 1'b0);
    tick();
    idle();
    #1;
    chk("t5_d_dbg_rvalid", dbg_rvalid, 1'b1);
    chk("t5_d_dbg_rdata", dbg_rdata, 32'h1111_1111);
    tick();

    // Reset right after a debug read accept: the response must never show.
    dbg_req(1'b0, 14'h0004, '0, 4'hF);
    tick();
    idle();
    RST_N = 1'b0;
    #2 chk("t6_rvalid_in_reset", dbg_rvalid, 1'b0);
    tick();
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t6_rvalid_after", dbg_rvalid, 1'b0);
      tick();
    end

`ifdef DMEM_ARB_STATS_EN
    chk("stats_conflict_reset", conflict_cnt, 32'd0);
    chk("stats_force_reset", force_cnt, 16'd0);
`endif

    // Continuous contention: forced debug slot every 9th cycle.
    cpu_req(1'b0, 14'h0005, '0, 4'hF);
    dbg_req(1'b1, 14'h0006, 32'hA5A5_0000, 4'h3);
    for (int i = 1; i <= 18; i++) begin
      #1;
      chk("t4_cpu_ready", cpu_req_ready, (i % 9) != 0);
      chk("t4_dbg_ready", dbg_req_ready, (i % 9) == 0);
      tick();
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stats_force_cnt", force_cnt, 16'd2);
    chk("stats_conflict_cnt", conflict_cnt, 32'd18);
`endif

    // Reset asserted at random phases with both requests active.
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK);
      phase = $urandom_range(2, 7);
      if (phase >= 5) phase++;
      #(phase);
      RST_N = 1'b0;
      #1;
      chk("t1_cpu_ready", cpu_req_ready, 1'b0);
      chk("t1_dbg_ready", dbg_req_ready, 1'b0);
      chk("t1_mem_en", mem_en, 1'b0);
      chk("t1_mem_addr", mem_addr, '0);
      chk("t1_mem_wdata", mem_wdata, '0);
      chk("t1_cpu_rvalid", cpu_rvalid, 1'b0);
      chk("t1_dbg_rvalid", dbg_rvalid, 1'b0);
      tick();
      tick();
      RST_N = 1'b1;
      tick();
    end

    // Randomized traffic; requests held until accepted.
    idle();
    for (int n = 0; n < 4000; n++) begin
      if (!cpu_req_valid || c_fired) begin
        cpu_req_valid = ($urandom_range(0, 99) < 60);
        cpu_we        = $urandom_range(0, 1) == 1;
        cpu_addr      = AW'($urandom_range(0, 15));
        cpu_wdata     = $urandom;
        cpu_be        = BW'($urandom_range(0, 15));
      end
      if (d_fired_rd) begin
        dbg_req_valid = 1'b0;
      end else if (!dbg_req_valid || d_fired) begin
        dbg_req_valid = ($urandom_range(0, 99) < 50);
        dbg_we        = $urandom_range(0, 1) == 1;
        dbg_addr      = AW'($urandom_range(0, 15));
        dbg_wdata     = $urandom;
        dbg_be        = BW'($urandom_range(0, 15));
      end
      tick();
    end
    idle();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
